// File: rtl/btn_pkg.sv
// btn_pkg: shared types and helpers for the pushbutton conditioner.
// Holds the auto-repeat state enum and the ms-to-cycles conversion.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   // A zero-length interval would leave a counter with no terminal count.
   function automatic int unsigned ms_to_cycles(
      input int unsigned clk_hz,
      input int unsigned ms
   );
      int unsigned cyc;
      cyc = clk_hz / 1000 * ms;
      return (cyc == 0) ? 32'd1 : cyc;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit.
// Reusable for any front-panel input; clears to 0 on reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronize, debounce and edge-detect a pushbutton.
// Define AUTOREPEAT_EN to add press-and-hold auto-repeat on step.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned DEBOUNCE_MS     = 20,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_MS  = 100
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic level,
   output logic press,
   // "release" is a reserved word, hence the suffix.
   output logic release_o,
   output logic step
);

   localparam int unsigned DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int DB_W = $clog2(DB_CYC) + 1;
   localparam logic [DB_W-1:0] DB_TC = DB_W'(DB_CYC - 1);

   logic            sync;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic            rel_q, rel_d;
   logic            step_w;

   sync_2ff u_sync (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .d_i    (btn),
      .q_o    (sync)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt_q <= '0;
         level_q  <= 1'b0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
      end
   end

   always_comb begin
      db_cnt_d = db_cnt_q + DB_W'(1);
      level_d  = level_q;
      if (sync == level_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_TC) begin
         db_cnt_d = '0;
         level_d  = ~level_q;
      end
      press_d = level_d & ~level_q;
      rel_d   = ~level_d & level_q;
   end

`ifdef AUTOREPEAT_EN
   localparam int unsigned DLY_CYC =
      ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
   localparam int unsigned RPT_CYC =
      ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
   localparam int unsigned RC_MAX =
      (DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC;
   localparam int RC_W = $clog2(RC_MAX) + 1;
   localparam logic [RC_W-1:0] DLY_TC = RC_W'(DLY_CYC - 1);
   localparam logic [RC_W-1:0] RPT_TC = RC_W'(RPT_CYC - 1);
   localparam logic [RC_W-1:0] RC_SAT = RC_W'(RC_MAX - 1);

   rpt_state_e      state_q, state_d;
   logic [RC_W-1:0] rc_q, rc_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         rc_q    <= rc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rc_d    = (rc_q == RC_SAT) ? rc_q : rc_q + RC_W'(1);
      unique case (state_q)
         IDLE: begin
            rc_d = '0;
            if (press_q) state_d = DELAY;
         end
         DELAY: begin
            if (!level_q) begin
               state_d = IDLE;
               rc_d    = '0;
            end else if (rc_q == DLY_TC) begin
               state_d = REPEAT;
               rc_d    = '0;
            end
         end
         REPEAT: begin
            if (!level_q) begin
               state_d = IDLE;
               rc_d    = '0;
            end else if (rc_q == RPT_TC) begin
               rc_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            rc_d    = '0;
         end
      endcase
   end

   // A falling level wins over a same-cycle terminal count.
   always_comb begin
      step_w = 1'b0;
      unique case (state_q)
         IDLE:    step_w = press_q;
         DELAY:   step_w = level_q && (rc_q == DLY_TC);
         REPEAT:  step_w = level_q && (rc_q == RPT_TC);
         default: step_w = 1'b0;
      endcase
   end
`else
   assign step_w = press_q;
`endif

   assign level     = level_q;
   assign press     = press_q;
   assign release_o = rel_q;
   assign step      = step_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scoreboard bench for btn_conditioner.
// Define AUTOREPEAT_EN for both DUT and bench to cover auto-repeat.
module tb_btn_conditioner;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   logic btn     = 1'b0;
   logic level;
   logic press;
   logic rls;
   logic step;

   always #5 clk = ~clk;

   btn_conditioner #(
      .CLK_HZ          (1000),
      .DEBOUNCE_MS     (4),
      .REPEAT_DELAY_MS (10),
      .REPEAT_RATE_MS  (3)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn       (btn),
      .level     (level),
      .press     (press),
      .release_o (rls),
      .step      (step)
   );

   // out = {level, press, release, step}
   typedef struct {
      int         cyc;
      logic [3:0] out;
   } ev_t;

   localparam logic [3:0] PRS = 4'b1101;
   localparam logic [3:0] STP = 4'b1001;
   localparam logic [3:0] REL = 4'b0010;

   ev_t  exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   t;
   logic step_prev = 1'b0;

   task automatic chk(
      input string      tag,
      input logic [3:0] obs,
      input logic [3:0] exp
   );
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @%0d: got %b want %b",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic ev(input int c, input logic [3:0] o);
      exp_q.push_back('{cyc: c, out: o});
   endtask

   task automatic run(input int n);
      ev_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         chk("press_rel_excl", {3'b0, press & rls}, 4'b0);
         chk("step_b2b", {3'b0, step & step_prev}, 4'b0);
         step_prev = step;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("event", {level, press, rls, step}, e.out);
         end else begin
            chk("no_pulse", {1'b0, press, rls, step}, 4'b0);
         end
      end
   endtask

`ifdef AUTOREPEAT_EN
   int rep_off[7] = '{16, 19, 22, 25, 28, 31, 34};
`endif

   initial begin
      // reset state
      reset_n = 1'b0;
      btn     = 1'b0;
      #2;
      chk("reset_outs", {level, press, rls, step}, 4'b0);
      run(3);
      reset_n = 1'b1;
      run(4);

      // clean press, held 8 cycles
      t = cyc;
      btn = 1'b1;
      ev(t + 6, PRS);
      run(8);
      chk("s1_level_hold", {3'b0, level}, 4'b1);
      btn = 1'b0;
      ev(t + 14, REL);
      run(20);

      // bounce: 3-cycle spans never reach the debounce count
      for (int k = 0; k < 5; k++) begin
         btn = 1'b1;
         run(3);
         btn = 1'b0;
         run(3);
      end
      chk("s2_level_low", {3'b0, level}, 4'b0);
      t = cyc;
      btn = 1'b1;
      ev(t + 6, PRS);
      run(10);
      btn = 1'b0;
      // level falls on the delay terminal count: no step
      ev(t + 16, REL);
      run(12);

      // auto-repeat: held 30 cycles
      t = cyc;
      btn = 1'b1;
      ev(t + 6, PRS);
`ifdef AUTOREPEAT_EN
      foreach (rep_off[j]) ev(t + rep_off[j], STP);
`endif
      run(30);
      chk("s3_level_hold", {3'b0, level}, 4'b1);
      btn = 1'b0;
      ev(t + 36, REL);
      run(15);

      // release lands on the repeat terminal count
      t = cyc;
      btn = 1'b1;
      ev(t + 6, PRS);
`ifdef AUTOREPEAT_EN
      ev(t + 16, STP);
      ev(t + 19, STP);
`endif
      run(16);
      btn = 1'b0;
      ev(t + 22, REL);
      run(15);

      // reset mid-REPEAT with the button held
      t = cyc;
      btn = 1'b1;
      ev(t + 6, PRS);
`ifdef AUTOREPEAT_EN
      ev(t + 16, STP);
      ev(t + 19, STP);
`endif
      run(20);
      reset_n = 1'b0;
      #1;
      chk("rst_async", {level, press, rls, step}, 4'b0);
      run(3);
      reset_n = 1'b1;
      t = cyc;
      ev(t + 6, PRS);
      run(1);
      chk("rst_no_step", {3'b0, step}, 4'b0);
      run(7);
      btn = 1'b0;
      ev(t + 14, REL);
      run(20);

      n_cmp++;
      assert (exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL queue_empty: got %0d want 0",
                exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
